imem_loader: RTL and testbench

- Upstream feeder for the Risc32 core's instruction memory.
- Accepts a byte stream over a valid/ready handshake and assembles bytes into 32-bit little-endian instruction words.
- Writes each word into consecutive instruction-memory rows from row 0, and holds the core in reset until the image is complete.
- Replaces direct testbench pokes of instruction-memory contents with a synthesizable boot path.

---
 rtl/imem_loader.sv | 171 +++++++++++++++++
 tb/tb_imem_loader.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: byte-stream boot loader for the Risc32 instruction memory.
// Optional trailer checksum is built in when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader #(
   parameter int ROWS   = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              im_we,
   output logic [ADDR_W-1:0] im_addr,
   output logic [31:0]       im_wdata,
   output logic              cpu_hold,
   output logic              done,
   output logic              error
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR0,
      S_HDR1,
      S_DATA,
      S_WRITE,
      S_DONE,
      S_ERR
`ifdef IMEM_LOADER_CHECKSUM_EN
      , S_CSUM
`endif
   } state_t;

`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam state_t FIN = S_CSUM;
`else
   localparam state_t FIN = S_DONE;
`endif

   state_t      state;
   state_t      nxt;
   logic [15:0] cnt;
   logic [15:0] wcnt;
   logic [1:0]  bcnt;
   logic [23:0] acc;
   logic [15:0] hdr;
   logic        last;
   logic        can_start;

   // header count as it will look once the high byte lands
   assign hdr       = {in_data, cnt[7:0]};
   assign last      = (wcnt + 16'd1) == cnt;
   assign can_start = start &&
                      (state == S_IDLE || state == S_DONE ||
                       state == S_ERR);

`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0] csum;

   // running XOR of payload bytes, restarted with every load
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         csum <= 8'd0;
      end else if (can_start) begin
         csum <= 8'd0;
      end else if (state == S_DATA && in_valid) begin
         csum <= csum ^ in_data;
      end
   end
`endif

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= nxt;
   end

   // next-state and per-state control outputs
   always_comb begin
      nxt      = state;
      in_ready = 1'b0;
      im_we    = 1'b0;
      cpu_hold = 1'b1;
      done     = 1'b0;
      error    = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (start) nxt = S_HDR0;
         end
         S_HDR0: begin
            in_ready = 1'b1;
            if (in_valid) nxt = S_HDR1;
         end
         S_HDR1: begin
            in_ready = 1'b1;
            if (in_valid) begin
               if (hdr == 16'd0)
                  nxt = FIN;
               else if (hdr > 16'(ROWS))
                  nxt = S_ERR;
               else
                  nxt = S_DATA;
            end
         end
         S_DATA: begin
            in_ready = 1'b1;
            if (in_valid && bcnt == 2'd3) nxt = S_WRITE;
         end
         S_WRITE: begin
            im_we = 1'b1;
            nxt   = last ? FIN : S_DATA;
         end
         S_DONE: begin
            done     = 1'b1;
            cpu_hold = 1'b0;
            if (start) nxt = S_HDR0;
         end
         S_ERR: begin
            error = 1'b1;
            if (start) nxt = S_HDR0;
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         S_CSUM: begin
            in_ready = 1'b1;
            if (in_valid)
               nxt = (in_data == csum) ? S_DONE : S_ERR;
         end
`endif
         default: nxt = S_IDLE;
      endcase
   end

   // header capture, byte assembly and write-port registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt      <= 16'd0;
         wcnt     <= 16'd0;
         bcnt     <= 2'd0;
         acc      <= 24'd0;
         im_addr  <= '0;
         im_wdata <= 32'd0;
      end else begin
         if (can_start) begin
            cnt  <= 16'd0;
            wcnt <= 16'd0;
            bcnt <= 2'd0;
            acc  <= 24'd0;
         end
         if (state == S_HDR0 && in_valid)
            cnt[7:0] <= in_data;
         if (state == S_HDR1 && in_valid)
            cnt[15:8] <= in_data;
         if (state == S_DATA && in_valid) begin
            bcnt <= bcnt + 2'd1;
            unique case (bcnt)
               2'd0: acc[7:0]   <= in_data;
               2'd1: acc[15:8]  <= in_data;
               2'd2: acc[23:16] <= in_data;
               2'd3: begin
                  // port regs load now so they are valid in WRITE
                  im_addr  <= wcnt[ADDR_W-1:0];
                  im_wdata <= {in_data, acc};
               end
            endcase
         end
         if (state == S_WRITE)
            wcnt <= wcnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized loads checked against a byte-list model.
// Trailer bytes are sent when IMEM_LOADER_CHECKSUM_EN is defined.
module tb_imem_loader;

   localparam int ROWS   = 32;
   localparam int ADDR_W = 5;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic              in_valid = 1'b0;
   logic [7:0]        in_data = 8'd0;
   logic              in_ready;
   logic              im_we;
   logic [ADDR_W-1:0] im_addr;
   logic [31:0]       im_wdata;
   logic              cpu_hold;
   logic              done;
   logic              error;

   int nvec = 0;
   int nfail = 0;
   int ready_bad = 0;
   bit flip = 1'b0;

   logic [ADDR_W-1:0] obs_a[$];
   logic [31:0]       obs_d[$];
   logic [7:0]        byte_q[$];

   always #5 clk = ~clk;

   imem_loader #(.ROWS(ROWS), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .im_we(im_we),
      .im_addr(im_addr), .im_wdata(im_wdata),
      .cpu_hold(cpu_hold), .done(done), .error(error)
   );

   // record every memory write seen mid-cycle
   always @(negedge clk) begin
      if (rst_n && im_we) begin
         obs_a.push_back(im_addr);
         obs_d.push_back(im_wdata);
         if (in_ready !== 1'b0) ready_bad++;
      end
   end

   function automatic logic [31:0] exp_word(input int i);
      logic [31:0] w = 32'd0;
      for (int k = 0; k < 4; k++)
         w = w + (32'(byte_q[4*i+k]) << (8*k));
      return w;
   endfunction

   function automatic logic [7:0] exp_xor(input int n);
      logic [7:0] x = 8'd0;
      for (int k = 0; k < n; k++) x = x ^ byte_q[k];
      return x;
   endfunction

   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      in_valid = 1'b1;
      in_data  = b;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         nfail++;
         $display("FAIL send_byte timeout byte=%h", b);
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_end();
      int n = 0;
      while (!(done || error) && n < 40) begin
         @(negedge clk);
         n++;
      end
      nvec++;
      if (!(done || error)) begin
         nfail++;
         $display("FAIL wait_end: no done/error in 40 cycles");
      end
   endtask

   task automatic run_load(input int cnt, input int gap_at,
                           input bit noise);
      obs_a.delete();
      obs_d.delete();
      ready_bad = 0;
      pulse_start();
      send_byte(cnt[7:0]);
      send_byte(cnt[15:8]);
      if (cnt <= ROWS) begin
         for (int i = 0; i < cnt*4; i++) begin
            if (i == gap_at) repeat (3) @(negedge clk);
            if (noise && i + 1 < cnt*4 && $urandom_range(0, 3) == 0)
               start = 1'b1;
            send_byte(byte_q[i]);
            start = 1'b0;
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         send_byte(exp_xor(cnt*4) ^ {7'd0, flip});
`endif
      end
      wait_end();
   endtask

   task automatic fill_random(input int n);
      byte_q.delete();
      for (int i = 0; i < n; i++)
         byte_q.push_back(8'($urandom_range(0, 255)));
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      nvec++;
      if ({in_ready, im_we, cpu_hold, done, error} !== 5'b00100 ||
          im_addr !== '0 || im_wdata !== 32'd0) begin
         nfail++;
         $display("FAIL reset: rdy/we/hold/done/err=%b addr=%h wd=%h",
                  {in_ready, im_we, cpu_hold, done, error},
                  im_addr, im_wdata);
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      nvec++;
      if ({in_ready, im_we, cpu_hold, done, error} !== 5'b00100) begin
         nfail++;
         $display("FAIL idle: rdy/we/hold/done/err=%b want 00100",
                  {in_ready, im_we, cpu_hold, done, error});
      end
   endtask

   task automatic test_two_words(input int gap_at);
      byte_q = '{8'h00, 8'h70, 8'h00, 8'h00,
                 8'h02, 8'h03, 8'h00, 8'h00};
      run_load(2, gap_at, 1'b0);
      nvec++;
      if (obs_a.size() != 2) begin
         nfail++;
         $display("FAIL two_words count: got %0d want 2", obs_a.size());
      end
      nvec++;
      if (obs_a.size() == 2 &&
          (obs_a[0] !== 5'd0 || obs_d[0] !== 32'h00007000 ||
           obs_a[1] !== 5'd1 || obs_d[1] !== 32'h00000302)) begin
         nfail++;
         $display("FAIL two_words data: %h@%0d %h@%0d",
                  obs_d[0], obs_a[0], obs_d[1], obs_a[1]);
      end
      nvec++;
      if ({done, error, cpu_hold, in_ready} !== 4'b1000) begin
         nfail++;
         $display("FAIL two_words status: got %b want 1000",
                  {done, error, cpu_hold, in_ready});
      end
      nvec++;
      if (ready_bad != 0) begin
         nfail++;
         $display("FAIL write_ready: in_ready high in %0d writes",
                  ready_bad);
      end
      nvec++;
      if (im_addr !== 5'd1 || im_wdata !== 32'h00000302) begin
         nfail++;
         $display("FAIL hold_port: addr=%h wd=%h want 1/302",
                  im_addr, im_wdata);
      end
   endtask

   task automatic test_oversize();
      byte_q.delete();
      run_load(33, -1, 1'b0);
      nvec++;
      if ({done, error, cpu_hold, in_ready} !== 4'b0110 ||
          obs_a.size() != 0) begin
         nfail++;
         $display("FAIL oversize: status=%b writes=%0d want 0110/0",
                  {done, error, cpu_hold, in_ready}, obs_a.size());
      end
      run_load(0, -1, 1'b0);
      nvec++;
      if ({done, error, cpu_hold, in_ready} !== 4'b1000 ||
          obs_a.size() != 0) begin
         nfail++;
         $display("FAIL empty: status=%b writes=%0d want 1000/0",
                  {done, error, cpu_hold, in_ready}, obs_a.size());
      end
   endtask

   task automatic test_load(input string name, input int n,
                            input bit noise);
      int gap;
      gap = noise ? int'($urandom_range(0, 4*n - 1)) : -1;
      fill_random(4*n);
      run_load(n, gap, noise);
      nvec++;
      if (obs_a.size() != n) begin
         nfail++;
         $display("FAIL %s count: got %0d want %0d",
                  name, obs_a.size(), n);
      end
      for (int i = 0; i < n && i < obs_a.size(); i++) begin
         nvec++;
         if (obs_a[i] !== ADDR_W'(i) || obs_d[i] !== exp_word(i)) begin
            nfail++;
            $display("FAIL %s word%0d: got %h@%0d want %h@%0d",
                     name, i, obs_d[i], obs_a[i], exp_word(i), i);
         end
      end
      nvec++;
      if ({done, error, cpu_hold} !== 3'b100 || ready_bad != 0) begin
         nfail++;
         $display("FAIL %s status: d/e/h=%b rdybad=%0d want 100/0",
                  name, {done, error, cpu_hold}, ready_bad);
      end
   endtask

   task automatic test_full_depth();
      test_load("full", ROWS, 1'b0);
      nvec++;
      if (im_addr !== ADDR_W'(ROWS - 1)) begin
         nfail++;
         $display("FAIL full last addr: got %0d want %0d",
                  im_addr, ROWS - 1);
      end
   endtask

   task automatic test_reset_midload();
      fill_random(8);
      pulse_start();
      send_byte(8'd2);
      send_byte(8'd0);
      for (int i = 0; i < 6; i++) send_byte(byte_q[i]);
      rst_n = 1'b0;
      #1;
      nvec++;
      if ({in_ready, im_we, cpu_hold, done, error} !== 5'b00100 ||
          im_addr !== '0 || im_wdata !== 32'd0) begin
         nfail++;
         $display("FAIL midreset: rdy/we/hold/done/err=%b addr=%h wd=%h",
                  {in_ready, im_we, cpu_hold, done, error},
                  im_addr, im_wdata);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      test_load("after_reset", 2, 1'b0);
   endtask

   task automatic test_random();
      for (int r = 0; r < 6; r++)
         test_load("random", int'($urandom_range(1, 8)), 1'b1);
   endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
   task automatic test_checksum();
      byte_q = '{8'hAA, 8'h55, 8'h0F, 8'hF0};
      flip = 1'b0;
      run_load(1, -1, 1'b0);
      nvec++;
      if ({done, error, cpu_hold} !== 3'b100 || obs_a.size() != 1 ||
          obs_d[0] !== 32'hF00F55AA) begin
         nfail++;
         $display("FAIL csum_ok: d/e/h=%b writes=%0d",
                  {done, error, cpu_hold}, obs_a.size());
      end
      flip = 1'b1;
      run_load(1, -1, 1'b0);
      flip = 1'b0;
      nvec++;
      if ({done, error, cpu_hold} !== 3'b011) begin
         nfail++;
         $display("FAIL csum_bad: d/e/h=%b want 011",
                  {done, error, cpu_hold});
      end
   endtask
`endif

   initial begin
      test_reset();
      test_two_words(-1);
      test_two_words(2);
      test_oversize();
      test_full_depth();
      test_reset_midload();
      test_random();
`ifdef IMEM_LOADER_CHECKSUM_EN
      test_checksum();
`endif
      $display("== %0d vectors applied, %0d miscompares ==",
               nvec, nfail);
      $finish;
   end

endmodule
